// File: rtl/wbu_fifo_pkg.sv
// Shared write-back entry layout and width constants for the wbu_fifo slice.
// The entry struct carries every field that travels from the LSU to write-back.
package wbu_fifo_pkg;

  localparam int CPU_WIDTH = 64;
  localparam int REG_ADDRW = 5;
  localparam int CSR_ADDRW = 12;
  localparam int INS_WIDTH = 32;

  typedef struct packed {
    logic [CPU_WIDTH-1:0] exres;
    logic [CPU_WIDTH-1:0] lsres;
    logic [CPU_WIDTH-1:0] csrd;
    logic [CPU_WIDTH-1:0] pc;
    logic [REG_ADDRW-1:0] rdid;
    logic [CSR_ADDRW-1:0] csrdid;
    logic                 lden;
    logic                 rdwen;
    logic                 csrdwen;
    logic                 ecall;
    logic                 mret;
    logic                 nop;
    logic [INS_WIDTH-1:0] ins;
    logic                 lsclint;
    logic                 device;
  } wbu_entry_t;

endpackage

// File: rtl/stl_fifo_sync.sv
// Generic synchronous FIFO: a pushed word is readable at the head one cycle later.
// The caller gates push/pop; flush empties the buffer and drops a same-cycle push.
module stl_fifo_sync #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // When full, a push may land in the slot being popped this same cycle.
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/wbu_fifo.sv
// Write-back buffer: DEPTH-entry in-order queue, one cycle push-to-head, commit gating and retire count.
// Accepts a push when not full or when the head pops in the same cycle; the head waits for i_post_ready.
module wbu_fifo #(
  parameter int DEPTH     = 2,
  parameter int CPU_WIDTH = 64,
  parameter int REG_ADDRW = 5,
  parameter int CSR_ADDRW = 12,
  parameter int INS_WIDTH = 32,
  parameter int CNT_WIDTH = 64
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_flush,
  input  logic                   i_pre_valid,
  output logic                   o_pre_ready,
  output logic                   o_post_valid,
  input  logic                   i_post_ready,
  input  logic                   i_iru_intr,
  input  logic [CPU_WIDTH-1:0]   i_lsu_exres,
  input  logic [CPU_WIDTH-1:0]   i_lsu_lsres,
  input  logic [CPU_WIDTH-1:0]   i_lsu_csrd,
  input  logic [CPU_WIDTH-1:0]   i_lsu_pc,
  input  logic                   i_lsu_lden,
  input  logic                   i_lsu_rdwen,
  input  logic                   i_lsu_csrdwen,
  input  logic                   i_lsu_ecall,
  input  logic                   i_lsu_mret,
  input  logic                   i_lsu_nop,
  input  logic [REG_ADDRW-1:0]   i_lsu_rdid,
  input  logic [CSR_ADDRW-1:0]   i_lsu_csrdid,
  input  logic [INS_WIDTH-1:0]   s_lsu_ins,
  input  logic                   s_lsu_lsclint,
  input  logic                   s_lsu_device,
  output logic [REG_ADDRW-1:0]   o_wbu_rdid,
  output logic                   o_wbu_rdwen,
  output logic [CPU_WIDTH-1:0]   o_wbu_rd,
  output logic [CSR_ADDRW-1:0]   o_wbu_csrdid,
  output logic                   o_wbu_csrdwen,
  output logic [CPU_WIDTH-1:0]   o_wbu_csrd,
  output logic [CPU_WIDTH-1:0]   o_wbu_pc,
  output logic                   o_wbu_ecall,
  output logic                   o_wbu_mret,
  output logic                   o_wbu_nop,
  output logic                   o_wbu_commit,
  output logic [INS_WIDTH-1:0]   s_wbu_ins,
  output logic                   s_wbu_lsclint,
  output logic                   s_wbu_device,
  output logic [$clog2(DEPTH):0] o_count,
  output logic [CNT_WIDTH-1:0]   o_retire_cnt
);

  import wbu_fifo_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  wbu_entry_t in_e;
  wbu_entry_t head;
  logic       push;
  logic       pop;

  always_comb begin
    in_e         = '0;
    in_e.exres   = i_lsu_exres;
    in_e.lsres   = i_lsu_lsres;
    in_e.csrd    = i_lsu_csrd;
    in_e.pc      = i_lsu_pc;
    in_e.rdid    = i_lsu_rdid;
    in_e.csrdid  = i_lsu_csrdid;
    in_e.lden    = i_lsu_lden;
    in_e.rdwen   = i_lsu_rdwen;
    in_e.csrdwen = i_lsu_csrdwen;
    in_e.ecall   = i_lsu_ecall;
    in_e.mret    = i_lsu_mret;
    in_e.nop     = i_lsu_nop;
    in_e.ins     = s_lsu_ins;
    in_e.lsclint = s_lsu_lsclint;
    in_e.device  = s_lsu_device;
  end

  assign o_post_valid = (o_count != '0);
  assign pop          = o_post_valid & i_post_ready;
  assign o_pre_ready  = (o_count != FULL) | pop;
  assign push         = i_pre_valid & o_pre_ready;

  stl_fifo_sync #(
    .WIDTH ($bits(wbu_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .flush (i_flush),
    .push  (push),
    .pop   (pop),
    .wdata (in_e),
    .rdata (head),
    .count (o_count)
  );

  // An interrupt still retires the head slot but suppresses its architectural effects.
  assign o_wbu_commit  = pop & ~i_iru_intr;
  assign o_wbu_rdwen   = o_wbu_commit & head.rdwen;
  assign o_wbu_csrdwen = o_wbu_commit & head.csrdwen;
  assign o_wbu_rd      = head.lden ? head.lsres : head.exres;
  assign o_wbu_rdid    = head.rdid;
  assign o_wbu_csrdid  = head.csrdid;
  assign o_wbu_csrd    = head.csrd;
  assign o_wbu_pc      = head.pc;
  assign o_wbu_ecall   = head.ecall;
  assign o_wbu_mret    = head.mret;
  assign o_wbu_nop     = head.nop;
  assign s_wbu_ins     = head.ins;
  assign s_wbu_lsclint = head.lsclint;
  assign s_wbu_device  = head.device;

  // Flush does not clear this counter; a commit in the flush cycle still counts.
  always_ff @(posedge i_clk) begin
    if (i_rst)                         o_retire_cnt <= '0;
    else if (o_wbu_commit & ~head.nop) o_retire_cnt <= o_retire_cnt + 1'b1;
  end

endmodule

// File: tb/tb_wbu_fifo.sv
// Directed bench for wbu_fifo: a DEPTH=4 instance for datapath checks and a CNT_WIDTH=4 one for wrap.
module tb_wbu_fifo;

  logic        i_clk = 1'b0;
  logic        i_rst, i_flush, i_pre_valid, i_post_ready, i_iru_intr;
  logic [63:0] i_lsu_exres, i_lsu_lsres, i_lsu_csrd, i_lsu_pc;
  logic        i_lsu_lden, i_lsu_rdwen, i_lsu_csrdwen, i_lsu_ecall, i_lsu_mret, i_lsu_nop;
  logic [4:0]  i_lsu_rdid;
  logic [11:0] i_lsu_csrdid;
  logic [31:0] s_lsu_ins;
  logic        s_lsu_lsclint, s_lsu_device;

  logic        o_pre_ready, o_post_valid, o_wbu_rdwen, o_wbu_csrdwen, o_wbu_ecall, o_wbu_mret;
  logic        o_wbu_nop, o_wbu_commit, s_wbu_lsclint, s_wbu_device;
  logic [4:0]  o_wbu_rdid;
  logic [11:0] o_wbu_csrdid;
  logic [63:0] o_wbu_rd, o_wbu_csrd, o_wbu_pc, o_retire_cnt;
  logic [31:0] s_wbu_ins;
  logic [2:0]  o_count;

  // Second instance: shares clock, reset and payload; own handshake.
  logic        b_flush, b_pre_valid, b_post_ready, b_iru_intr;
  logic        b_pre_ready, b_post_valid, b_rdwen, b_csrdwen, b_ecall, b_mret, b_nop, b_commit;
  logic        b_lsclint, b_device;
  logic [4:0]  b_rdid;
  logic [11:0] b_csrdid;
  logic [63:0] b_rd, b_csrd, b_pc;
  logic [31:0] b_ins;
  logic [1:0]  b_count;
  logic [3:0]  b_retire_cnt;

  int tests = 0;
  int fails = 0;
  logic [63:0] exp_ret;

  always #5 i_clk = ~i_clk;

  wbu_fifo #(.DEPTH(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush),
    .i_pre_valid(i_pre_valid), .o_pre_ready(o_pre_ready),
    .o_post_valid(o_post_valid), .i_post_ready(i_post_ready), .i_iru_intr(i_iru_intr),
    .i_lsu_exres(i_lsu_exres), .i_lsu_lsres(i_lsu_lsres), .i_lsu_csrd(i_lsu_csrd), .i_lsu_pc(i_lsu_pc),
    .i_lsu_lden(i_lsu_lden), .i_lsu_rdwen(i_lsu_rdwen), .i_lsu_csrdwen(i_lsu_csrdwen),
    .i_lsu_ecall(i_lsu_ecall), .i_lsu_mret(i_lsu_mret), .i_lsu_nop(i_lsu_nop),
    .i_lsu_rdid(i_lsu_rdid), .i_lsu_csrdid(i_lsu_csrdid),
    .s_lsu_ins(s_lsu_ins), .s_lsu_lsclint(s_lsu_lsclint), .s_lsu_device(s_lsu_device),
    .o_wbu_rdid(o_wbu_rdid), .o_wbu_rdwen(o_wbu_rdwen), .o_wbu_rd(o_wbu_rd),
    .o_wbu_csrdid(o_wbu_csrdid), .o_wbu_csrdwen(o_wbu_csrdwen), .o_wbu_csrd(o_wbu_csrd),
    .o_wbu_pc(o_wbu_pc), .o_wbu_ecall(o_wbu_ecall), .o_wbu_mret(o_wbu_mret),
    .o_wbu_nop(o_wbu_nop), .o_wbu_commit(o_wbu_commit),
    .s_wbu_ins(s_wbu_ins), .s_wbu_lsclint(s_wbu_lsclint), .s_wbu_device(s_wbu_device),
    .o_count(o_count), .o_retire_cnt(o_retire_cnt)
  );

  wbu_fifo #(.DEPTH(2), .CNT_WIDTH(4)) dut_b (
    .i_clk(i_clk), .i_rst(i_rst), .i_flush(b_flush),
    .i_pre_valid(b_pre_valid), .o_pre_ready(b_pre_ready),
    .o_post_valid(b_post_valid), .i_post_ready(b_post_ready), .i_iru_intr(b_iru_intr),
    .i_lsu_exres(i_lsu_exres), .i_lsu_lsres(i_lsu_lsres), .i_lsu_csrd(i_lsu_csrd), .i_lsu_pc(i_lsu_pc),
    .i_lsu_lden(i_lsu_lden), .i_lsu_rdwen(i_lsu_rdwen), .i_lsu_csrdwen(i_lsu_csrdwen),
    .i_lsu_ecall(i_lsu_ecall), .i_lsu_mret(i_lsu_mret), .i_lsu_nop(i_lsu_nop),
    .i_lsu_rdid(i_lsu_rdid), .i_lsu_csrdid(i_lsu_csrdid),
    .s_lsu_ins(s_lsu_ins), .s_lsu_lsclint(s_lsu_lsclint), .s_lsu_device(s_lsu_device),
    .o_wbu_rdid(b_rdid), .o_wbu_rdwen(b_rdwen), .o_wbu_rd(b_rd),
    .o_wbu_csrdid(b_csrdid), .o_wbu_csrdwen(b_csrdwen), .o_wbu_csrd(b_csrd),
    .o_wbu_pc(b_pc), .o_wbu_ecall(b_ecall), .o_wbu_mret(b_mret),
    .o_wbu_nop(b_nop), .o_wbu_commit(b_commit),
    .s_wbu_ins(b_ins), .s_wbu_lsclint(b_lsclint), .s_wbu_device(b_device),
    .o_count(b_count), .o_retire_cnt(b_retire_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen 1 unit after that.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    i_rst = 1'b1; i_flush = 1'b0; i_pre_valid = 1'b1; i_post_ready = 1'b0; i_iru_intr = 1'b0;
    i_lsu_exres = '0; i_lsu_lsres = '0; i_lsu_csrd = '0; i_lsu_pc = 64'h1234;
    i_lsu_lden = 0; i_lsu_rdwen = 0; i_lsu_csrdwen = 0; i_lsu_ecall = 0; i_lsu_mret = 0; i_lsu_nop = 0;
    i_lsu_rdid = '0; i_lsu_csrdid = '0; s_lsu_ins = '0; s_lsu_lsclint = 0; s_lsu_device = 0;
    b_flush = 1'b0; b_pre_valid = 1'b0; b_post_ready = 1'b0; b_iru_intr = 1'b0;
    exp_ret = '0;

    // Reset held two cycles with a push request pending.
    tick(); tick();
    i_rst = 1'b0; i_pre_valid = 1'b0; i_post_ready = 1'b1;
    settle();
    chk("rst_post_valid", o_post_valid, 0);
    chk("rst_pre_ready", o_pre_ready, 1);
    chk("rst_count", o_count, 0);
    chk("rst_retire", o_retire_cnt, 0);
    chk("rst_commit", o_wbu_commit, 0);
    chk("rst_rdwen", o_wbu_rdwen, 0);
    chk("rst_csrdwen", o_wbu_csrdwen, 0);

    // Fill all four slots while downstream stalls.
    i_post_ready = 1'b0; i_pre_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      i_lsu_pc = 64'h8000_0000 + 64'(4 * k);
      tick();
    end
    i_pre_valid = 1'b0;
    settle();
    chk("full_count", o_count, 4);
    chk("full_pre_ready", o_pre_ready, 0);
    chk("full_head_pc", o_wbu_pc, 64'h8000_0000);

    // Push and pop together while full.
    i_pre_valid = 1'b1; i_post_ready = 1'b1; i_lsu_pc = 64'h8000_0010;
    settle();
    chk("full_pop_pre_ready", o_pre_ready, 1);
    chk("full_pop_commit", o_wbu_commit, 1);
    tick();
    exp_ret = exp_ret + 1;
    i_pre_valid = 1'b0;
    settle();
    chk("simul_count", o_count, 4);
    for (int k = 1; k <= 4; k++) begin
      chk("drain_pc", o_wbu_pc, 64'h8000_0000 + 64'(4 * k));
      tick();
      exp_ret = exp_ret + 1;
    end
    chk("drain_count", o_count, 0);
    chk("drain_retire", o_retire_cnt, exp_ret);

    // Load result selected; write enables only in the handshake cycle.
    i_post_ready = 1'b0; i_pre_valid = 1'b1;
    i_lsu_lden = 1; i_lsu_lsres = 64'hDEAD; i_lsu_exres = 64'hBEEF; i_lsu_rdwen = 1; i_lsu_csrdwen = 1;
    i_lsu_rdid = 5'd7; i_lsu_pc = 64'h100;
    tick();
    i_pre_valid = 1'b0;
    settle();
    chk("ld_rd", o_wbu_rd, 64'hDEAD);
    chk("ld_rdid", o_wbu_rdid, 7);
    chk("stall_rdwen", o_wbu_rdwen, 0);
    chk("stall_csrdwen", o_wbu_csrdwen, 0);
    i_post_ready = 1'b1;
    settle();
    chk("hs_rdwen", o_wbu_rdwen, 1);
    chk("hs_csrdwen", o_wbu_csrdwen, 1);
    tick();
    exp_ret = exp_ret + 1;

    // Execute result selected.
    i_post_ready = 1'b0; i_pre_valid = 1'b1; i_lsu_lden = 0;
    tick();
    i_pre_valid = 1'b0;
    settle();
    chk("ex_rd", o_wbu_rd, 64'hBEEF);

    // Interrupt pops the head without committing it.
    i_iru_intr = 1'b1; i_post_ready = 1'b1;
    settle();
    chk("intr_commit", o_wbu_commit, 0);
    chk("intr_rdwen", o_wbu_rdwen, 0);
    chk("intr_csrdwen", o_wbu_csrdwen, 0);
    tick();
    i_iru_intr = 1'b0; i_post_ready = 1'b0;
    i_lsu_rdwen = 0; i_lsu_csrdwen = 0;
    settle();
    chk("intr_count", o_count, 0);
    chk("intr_retire", o_retire_cnt, exp_ret);

    // Flush with a concurrent push and pop.
    i_pre_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      i_lsu_pc = 64'hA0 + 64'(4 * k);
      tick();
    end
    settle();
    chk("pre_flush_count", o_count, 3);
    i_flush = 1'b1; i_post_ready = 1'b1; i_lsu_pc = 64'hBAD;
    settle();
    chk("flush_commit", o_wbu_commit, 1);
    chk("flush_head_pc", o_wbu_pc, 64'hA0);
    tick();
    exp_ret = exp_ret + 1;
    i_flush = 1'b0; i_pre_valid = 1'b0; i_post_ready = 1'b0;
    settle();
    chk("flush_count", o_count, 0);
    chk("flush_post_valid", o_post_valid, 0);
    chk("flush_retire", o_retire_cnt, exp_ret);
    i_pre_valid = 1'b1; i_lsu_pc = 64'hC0;
    tick();
    i_pre_valid = 1'b0;
    settle();
    chk("post_flush_count", o_count, 1);
    chk("post_flush_pc", o_wbu_pc, 64'hC0);
    i_post_ready = 1'b1;
    tick();
    exp_ret = exp_ret + 1;

    // Streaming: five commits, two of them nops, one entry per cycle.
    i_pre_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      i_lsu_nop = k[0];
      i_lsu_pc = 64'h200 + 64'(4 * k);
      tick();
      if (k > 0) chk("stream_count", o_count, 1);
    end
    i_pre_valid = 1'b0; i_lsu_nop = 0;
    tick();
    exp_ret = exp_ret + 3;
    chk("stream_retire", o_retire_cnt, exp_ret);
    chk("stream_empty", o_post_valid, 0);

    // Narrow counter wraps after 16 commits.
    b_pre_valid = 1'b1; b_post_ready = 1'b1;
    for (int k = 0; k < 15; k++) tick();
    b_pre_valid = 1'b0;
    tick();
    chk("b_retire_15", b_retire_cnt, 4'hF);
    chk("b_count", b_count, 0);
    b_pre_valid = 1'b1;
    tick();
    b_pre_valid = 1'b0;
    tick();
    chk("b_retire_wrap", b_retire_cnt, 4'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
